// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Parametrised VGA timing + test-pattern generator with a Wishbone slave
//   register file. Counters and pixel outputs advance only on i_pix_ce.
//   Software-visible CTRL/COLOR are staging registers; they are copied into
//   the active set on the frame-start pixel so a frame is never torn.
//
// Ports
//   i_clk, i_rst            clock, async active-high reset
//   i_pix_ce                pixel clock enable
//   i_wb_*                  Wishbone slave (adr, dat_w, sel, we, cyc, stb)
//   o_wb_dat_r, o_wb_ack    registered read data, single-cycle ack
//   o_vga_h_sync/v_sync     syncs, active level SYNC_POL
//   o_vga_vid_en            active-video flag
//   o_vga_red/green/blue    CW-bit channels, nibble in the MSBs
//   o_irq                   frame interrupt
//
// Build option
//   VGA_GEN_FRAME_IRQ_EN    when defined, a pending bit (STATUS[17], W1C) is
//                           set at the start of vblank and drives o_irq;
//                           otherwise o_irq is tied low.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pix_ce,
  input  logic [5:0]    i_wb_adr,
  input  logic [31:0]   i_wb_dat_w,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_dat_r,
  output logic          o_wb_ack,
  output logic          o_vga_h_sync,
  output logic          o_vga_v_sync,
  output logic          o_vga_vid_en,
  output logic [CW-1:0] o_vga_red,
  output logic [CW-1:0] o_vga_green,
  output logic [CW-1:0] o_vga_blue,
  output logic          o_irq
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Bars need h[8:6] and the checker needs v[5], so keep minimum widths.
  localparam int HW = ($clog2(H_TOTAL) < 9) ? 9 : $clog2(H_TOTAL);
  localparam int VW = ($clog2(V_TOTAL) < 6) ? 6 : $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HA_L   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VA_L   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic [CW-1:0] expand(input logic [3:0] nib);
    logic [CW-1:0] c;
    c = '0;
    c[CW-1 -: 4] = nib;
    return c;
  endfunction

  // ---------------- counters / timing ----------------
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          line_end, frame_end, active, hs_act, vs_act, vblank;

  assign line_end  = (h_q == H_LAST);
  assign frame_end = line_end && (v_q == V_LAST);
  assign active    = (h_q < HA_L) && (v_q < VA_L);
  assign hs_act    = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_act    = (v_q >= VS_BEG) && (v_q < VS_END);
  assign vblank    = (v_q >= VA_L);

  always_comb begin
    h_d = line_end ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (line_end) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
  end

  // ---------------- registers ----------------
  logic        en_s_q, en_a_q;
  logic [1:0]  mode_s_q, mode_a_q;
  logic [11:0] col_s_q, col_a_q;
  logic [15:0] frame_q;
  logic        pend;
  logic        ack_q;
  logic [31:0] dat_q, rd_data;
  logic        wb_acc, wb_wr;

  assign wb_acc = i_wb_cyc && i_wb_stb && !ack_q;
  assign wb_wr  = wb_acc && i_wb_we;

  // ---------------- pattern ----------------
  logic [3:0] nr, ng, nb;
  always_comb begin
    {nr, ng, nb} = 12'h000;
    case (mode_a_q)
      2'd0: {nr, ng, nb} = col_a_q;
      2'd1: begin
        nr = {4{h_q[8]}};
        ng = {4{h_q[7]}};
        nb = {4{h_q[6]}};
      end
      2'd2: if (h_q[5] ^ v_q[5]) {nr, ng, nb} = col_a_q;
      default:
        if (h_q == '0 || h_q == HA_L - 1'b1 || v_q == '0 || v_q == VA_L - 1'b1)
          {nr, ng, nb} = col_a_q;
    endcase
    if (!en_a_q || !active) {nr, ng, nb} = 12'h000;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_q          <= '0;
      v_q          <= '0;
      o_vga_h_sync <= ~SYNC_POL;
      o_vga_v_sync <= ~SYNC_POL;
      o_vga_vid_en <= 1'b0;
      o_vga_red    <= '0;
      o_vga_green  <= '0;
      o_vga_blue   <= '0;
      en_a_q       <= 1'b0;
      mode_a_q     <= 2'd0;
      col_a_q      <= 12'hF00;
      frame_q      <= 16'd0;
    end else if (i_pix_ce) begin
      h_q          <= h_d;
      v_q          <= v_d;
      o_vga_h_sync <= hs_act ? SYNC_POL : ~SYNC_POL;
      o_vga_v_sync <= vs_act ? SYNC_POL : ~SYNC_POL;
      o_vga_vid_en <= active;
      o_vga_red    <= expand(nr);
      o_vga_green  <= expand(ng);
      o_vga_blue   <= expand(nb);
      // Staging is sampled before any same-clock write lands (NBA order),
      // so a write on this edge shows up one frame later.
      if (frame_end) begin
        en_a_q   <= en_s_q;
        mode_a_q <= mode_s_q;
        col_a_q  <= col_s_q;
        frame_q  <= frame_q + 16'd1;
      end
    end
  end

  // ---------------- Wishbone ----------------
  always_comb begin
    case (i_wb_adr[3:2])
      2'd0:    rd_data = {29'd0, mode_s_q, en_s_q};
      2'd1:    rd_data = {20'd0, col_s_q};
      2'd2:    rd_data = {14'd0, pend, vblank, frame_q};
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      en_s_q   <= 1'b0;
      mode_s_q <= 2'd0;
      col_s_q  <= 12'hF00;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
    end else begin
      ack_q <= wb_acc;
      if (wb_acc) dat_q <= rd_data;
      if (wb_wr && i_wb_adr[3:2] == 2'd0 && i_wb_sel[0]) begin
        en_s_q   <= i_wb_dat_w[0];
        mode_s_q <= i_wb_dat_w[2:1];
      end
      if (wb_wr && i_wb_adr[3:2] == 2'd1) begin
        if (i_wb_sel[0]) col_s_q[7:0]  <= i_wb_dat_w[7:0];
        if (i_wb_sel[1]) col_s_q[11:8] <= i_wb_dat_w[11:8];
      end
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_dat_r = dat_q;

  // ---------------- frame interrupt ----------------
`ifdef VGA_GEN_FRAME_IRQ_EN
  logic pend_q, irq_set, irq_clr;
  assign irq_set = i_pix_ce && h_q == '0 && v_q == VA_L;
  assign irq_clr = wb_wr && i_wb_adr[3:2] == 2'd2 && i_wb_sel[2] && i_wb_dat_w[17];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        pend_q <= 1'b0;
    else if (irq_set) pend_q <= 1'b1;   // set beats a simultaneous clear
    else if (irq_clr) pend_q <= 1'b0;
  end

  assign pend  = pend_q;
  assign o_irq = pend_q;

  logic unused_bits;
  assign unused_bits = ^{i_wb_adr[5:4], i_wb_adr[1:0], i_wb_dat_w[31:18],
                         i_wb_dat_w[16:12], i_wb_sel[3]};
`else
  assign pend  = 1'b0;
  assign o_irq = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{i_wb_adr[5:4], i_wb_adr[1:0], i_wb_dat_w[31:12],
                         i_wb_sel[3:2]};
`endif

endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;
  localparam int HA = 640, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;   // 656
  localparam int VT = VA + VFP + VS + VBP;   // 8
  localparam bit POL = 1'b0;
  localparam int CW = 4;

  logic          clk = 1'b0, rst = 1'b1, pix_ce = 1'b1;
  logic [5:0]    adr = '0;
  logic [31:0]   dat_w = '0;
  logic [3:0]    sel = '0;
  logic          we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [31:0]   dat_r;
  logic          ack, hsync, vsync, vid_en, irq;
  logic [CW-1:0] red, green, blue;

  int nchk = 0, nerr = 0;
  bit half_ce = 1'b0;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL), .CW(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_ce(pix_ce),
    .i_wb_adr(adr), .i_wb_dat_w(dat_w), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_dat_r(dat_r), .o_wb_ack(ack),
    .o_vga_h_sync(hsync), .o_vga_v_sync(vsync), .o_vga_vid_en(vid_en),
    .o_vga_red(red), .o_vga_green(green), .o_vga_blue(blue),
    .o_irq(irq)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    pix_ce = half_ce ? ~pix_ce : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          n = 0;                 // pixel enables since reset
  logic        stg_en = 0, act_en = 0;
  logic [1:0]  stg_mode = 0, act_mode = 0;
  logic [11:0] stg_col = 12'hF00, act_col = 12'hF00;
  logic [15:0] fcnt = 0;
  logic        pend = 0, m_ack = 0;
  logic [31:0] m_dat = 0;
  logic        exp_hs = ~POL, exp_vs = ~POL, exp_ve = 0;
  logic [11:0] exp_rgb = 0;
  int          disp_h = 0, disp_v = 0;

  function automatic logic [11:0] pix(input int h, input int v);
    int idx;
    if (!(h < HA && v < VA) || !act_en) return 12'h000;
    case (act_mode)
      2'd0: return act_col;
      2'd1: begin
        idx = (h / 64) % 8;
        return {((idx & 4) != 0) ? 4'hF : 4'h0,
                ((idx & 2) != 0) ? 4'hF : 4'h0,
                ((idx & 1) != 0) ? 4'hF : 4'h0};
      end
      2'd2: return (((h / 32) % 2) != ((v / 32) % 2)) ? act_col : 12'h000;
      default: return (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) ? act_col : 12'h000;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a, input int cv);
    case (a)
      2'd0: return {29'd0, stg_mode, stg_en};
      2'd1: return {20'd0, stg_col};
      2'd2: return {14'd0, pend, (cv >= VA), fcnt};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int ch, cv;
    logic acc, fs;
    logic [31:0] rdv;
`ifdef VGA_GEN_FRAME_IRQ_EN
    logic iset, iclr;
`endif
    if (rst) begin
      n = 0; stg_en = 0; act_en = 0; stg_mode = 0; act_mode = 0;
      stg_col = 12'hF00; act_col = 12'hF00; fcnt = 0; pend = 0;
      m_ack = 0; m_dat = 0; exp_hs = ~POL; exp_vs = ~POL; exp_ve = 0;
      exp_rgb = 0; disp_h = 0; disp_v = 0;
      return;
    end
    ch  = n % HT;
    cv  = (n / HT) % VT;
    acc = cyc && stb && !m_ack;
    rdv = m_read(adr[3:2], cv);
    fs  = pix_ce && ch == HT - 1 && cv == VT - 1;
`ifdef VGA_GEN_FRAME_IRQ_EN
    iset = pix_ce && ch == 0 && cv == VA;
    iclr = acc && we && adr[3:2] == 2'd2 && sel[2] && dat_w[17];
`endif
    if (pix_ce) begin
      exp_hs  = (ch >= HA + HFP && ch < HA + HFP + HS) ? POL : ~POL;
      exp_vs  = (cv >= VA + VFP && cv < VA + VFP + VS) ? POL : ~POL;
      exp_ve  = (ch < HA && cv < VA);
      exp_rgb = pix(ch, cv);
      disp_h  = ch;
      disp_v  = cv;
      n++;
    end
    if (fs) begin
      act_en = stg_en; act_mode = stg_mode; act_col = stg_col;
      fcnt = fcnt + 16'd1;
    end
    if (acc && we) begin
      if (adr[3:2] == 2'd0 && sel[0]) begin
        stg_en = dat_w[0]; stg_mode = dat_w[2:1];
      end
      if (adr[3:2] == 2'd1) begin
        if (sel[0]) stg_col[7:0]  = dat_w[7:0];
        if (sel[1]) stg_col[11:8] = dat_w[11:8];
      end
    end
`ifdef VGA_GEN_FRAME_IRQ_EN
    if (iset) pend = 1'b1;
    else if (iclr) pend = 1'b0;
`endif
    m_ack = acc;
    if (acc) m_dat = rdv;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("h_sync", hsync, exp_hs);
    chk("v_sync", vsync, exp_vs);
    chk("vid_en", vid_en, exp_ve);
    chk("red", red, exp_rgb[11:8]);
    chk("green", green, exp_rgb[7:4]);
    chk("blue", blue, exp_rgb[3:0]);
    chk("ack", ack, m_ack);
    chk("dat_r", dat_r, m_dat);
    chk("irq", irq, pend);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wb_xfer(input logic w, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    int t;
    @(negedge clk);
    adr = a; dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    r = 32'hDEAD_BEEF;
    for (t = 0; t < 8; t++) begin
      @(negedge clk);
      if (ack) break;
    end
    if (t >= 8) chk("wb_ack_timeout", 0, 1);
    else r = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, s, r);
  endtask

  task automatic wb_rd(input logic [5:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'd0, 4'hF, r);
  endtask

  task automatic wait_pos(input int h, input int v);
    int t;
    for (t = 0; t < 4 * HT * VT; t++) begin
      @(negedge clk);
      if (disp_h == h && disp_v == v) break;
    end
    if (t >= 4 * HT * VT) chk("wait_pos_timeout", 0, 1);
  endtask

  function automatic logic sig(input int which);
    return (which == 0) ? hsync : vsync;
  endfunction

  // period and low width in clocks, measured from a falling edge
  task automatic measure(input int which, output int period, output int low);
    int t;
    logic p, s;
    period = -1; low = -1;
    p = sig(which);
    for (t = 0; t < 3 * HT * VT; t++) begin
      @(negedge clk);
      s = sig(which);
      if (p && !s) break;
      p = s;
    end
    if (t >= 3 * HT * VT) begin
      chk("sync_edge_timeout", 0, 1);
      return;
    end
    p = 1'b0;
    for (t = 1; t < 3 * HT * VT; t++) begin
      @(negedge clk);
      s = sig(which);
      if (s && low < 0) low = t;
      if (!s && p) begin
        period = t;
        break;
      end
      p = s;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] r;
    int per, low, hi_cnt;

    repeat (2) @(negedge clk);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_viden", vid_en, 0);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_r, 0);
    chk("rst_irq", irq, 0);
    rst = 1'b0;

    wb_rd(6'h00, r); chk("ctrl_reset", r, 32'h0);
    wb_rd(6'h04, r); chk("color_reset", r, 32'hF00);
    wb_rd(6'h0C, r); chk("reg_c_zero", r, 32'h0);
    wb_rd(6'h08, r); chk("status_reset", r, 32'h0);
    wb_wr(6'h0C, 32'hFFFF_FFFF, 4'hF);
    wb_rd(6'h0C, r); chk("reg_c_still_zero", r, 32'h0);

    measure(0, per, low);
    chk("hsync_period", per, HT);
    chk("hsync_low", low, HS);
    measure(1, per, low);
    chk("vsync_period", per, HT * VT);
    chk("vsync_low", low, HT * VS);

    // enable solid red
    wb_wr(6'h00, 32'h1, 4'h1);
    wait_pos(0, 0);
    wait_pos(10, 1);
    chk("solid_red_r", red, 4'hF);
    chk("solid_red_g", green, 4'h0);

    // mid-frame colour change: staged immediately, visible next frame
    wb_wr(6'h04, 32'h0F0, 4'hF);
    wb_rd(6'h04, r); chk("color_readback", r, 32'h0F0);
    wait_pos(300, 2);
    chk("same_frame_red", red, 4'hF);
    chk("same_frame_g", green, 4'h0);
    wait_pos(10, 1);
    chk("next_frame_g", green, 4'hF);
    chk("next_frame_r", red, 4'h0);

    // colour bars
    wb_wr(6'h00, 32'h3, 4'h1);
    wait_pos(0, 0);
    wait_pos(5, 1);   chk("bar0", {red, green, blue}, 12'h000);
    wait_pos(70, 1);  chk("bar1_blue", {red, green, blue}, 12'h00F);
    wait_pos(200, 1); chk("bar3_cyan", {red, green, blue}, 12'h0FF);
    wait_pos(450, 1); chk("bar7_white", {red, green, blue}, 12'hFFF);
    wait_pos(512, 1); chk("bar8_black", {red, green, blue}, 12'h000);

    // checker
    wb_wr(6'h00, 32'h5, 4'h1);
    wait_pos(0, 0);
    wait_pos(10, 1); chk("chk_off", green, 4'h0);
    wait_pos(40, 1); chk("chk_on", green, 4'hF);

    // border
    wb_wr(6'h00, 32'h7, 4'h1);
    wait_pos(0, 0);
    wait_pos(0, 1);   chk("border_left", green, 4'hF);
    wait_pos(5, 1);   chk("border_inner", green, 4'h0);
    wait_pos(639, 1); chk("border_right", green, 4'hF);
    wait_pos(5, 3);   chk("border_bottom", green, 4'hF);

    // byte-lane write
    wb_wr(6'h04, 32'hF00, 4'hF);
    wb_wr(6'h04, 32'hFFFF_FFFF, 4'h1);
    wb_rd(6'h04, r); chk("color_bytelane", r, 32'hFFF);

`ifdef VGA_GEN_FRAME_IRQ_EN
    wait_pos(10, 1);
    wb_wr(6'h08, 32'h0002_0000, 4'h4);
    @(negedge clk);
    chk("irq_cleared", irq, 0);
    for (int t = 0; t < 2 * HT * VT; t++) begin
      @(negedge clk);
      if (irq) break;
    end
    chk("irq_rise", irq, 1);
    chk("irq_rise_v", disp_v, VA);
    chk("irq_rise_h", disp_h, 0);
    wb_rd(6'h08, r); chk("status_pend", r[17], 1);
    wb_wr(6'h08, 32'h0002_0000, 4'h4);
    @(negedge clk);
    chk("irq_w1c", irq, 0);
`else
    hi_cnt = 0;
    for (int t = 0; t < 2 * HT * VT; t++) begin
      @(negedge clk);
      if (irq) hi_cnt++;
    end
    chk("irq_never_high", hi_cnt, 0);
    wb_wr(6'h08, 32'h0002_0000, 4'h4);
    wb_rd(6'h08, r); chk("status_pend_zero", r[17], 0);
`endif

    // pixel enable every other clock: periods double, outputs hold
    half_ce = 1'b1;
    measure(0, per, low);
    chk("half_hsync_period", per, 2 * HT);
    chk("half_hsync_low", low, 2 * HS);
    half_ce = 1'b0;

    // asynchronous reset mid-frame
    wait_pos(100, 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_hsync", hsync, 1);
    chk("mid_rst_viden", vid_en, 0);
    chk("mid_rst_rgb", {red, green, blue}, 0);
    chk("mid_rst_irq", irq, 0);
    @(negedge clk);
    rst = 1'b0;
    wb_rd(6'h00, r); chk("mid_rst_ctrl", r, 32'h0);
    wb_rd(6'h04, r); chk("mid_rst_color", r, 32'hF00);
    wb_rd(6'h08, r); chk("mid_rst_status", r, 32'h0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
